// File: rtl/uart_tx_arb_pkg.sv
// Shared encodings for the UART transmit arbiter: FSM states, baud select codes
// and the default abort timeout.
package uart_tx_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    BAUD_9600    = 3'd0,
    BAUD_19200   = 3'd1,
    BAUD_38400   = 3'd2,
    BAUD_57600   = 3'd3,
    BAUD_115200  = 3'd4,
    BAUD_1562500 = 3'd5
  } baud_e;

  localparam int TIMEOUT_DEF = 65535;

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin select: scans from last+1 upward with wrap and
// returns the first pending requester.
module uart_tx_arb_rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       last,
  output logic [2:0]       winner,
  output logic             any_req
);

  logic [7:0] req_ext;
  logic [3:0] idx;

  always_comb begin
    req_ext = 8'(req);
    winner  = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      // last < N_REQ and k <= N_REQ, so one subtraction wraps the sum
      idx = {1'b0, last} + 4'(k);
      if (idx >= 4'(N_REQ)) idx = idx - 4'(N_REQ);
      if (!any_req && req_ext[idx[2:0]]) begin
        any_req = 1'b1;
        winner  = idx[2:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sequencing N_REQ byte producers onto one UART transmitter:
// launch pulse, busy/done tracking with timeout abort, per-requester ack/done pulses.
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int          N_REQ    = 4,
  parameter logic [2:0]  BAUD_SEL = 3'(BAUD_115200),
  parameter int          TIMEOUT  = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     ack,
  output logic [N_REQ-1:0]     done,
  output logic                 err,
  output logic                 busy,
  output logic [2:0]           owner,
  output logic                 tx_send_en,
  output logic [7:0]           tx_data,
  output logic [2:0]           tx_baud_set,
  input  logic                 tx_done,
  input  logic                 tx_busy
);

  localparam logic [15:0] CNT_TERM = 16'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [2:0]         owner_q, owner_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic               err_q, err_d;
  logic               send_q, send_d;

  logic [2:0]         winner;
  logic               any_req;
  logic [N_REQ-1:0]   win_hot;
  logic [N_REQ-1:0]   owner_hot;
  logic [7:0]         win_data;

  uart_tx_arb_rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req     (req),
    .last    (owner_q),
    .winner  (winner),
    .any_req (any_req)
  );

  always_comb begin
    win_hot   = '0;
    owner_hot = '0;
    win_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      win_hot[i]   = (winner == 3'(i));
      owner_hot[i] = (owner_q == 3'(i));
      if (winner == 3'(i)) win_data = req_data[8*i +: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    tx_data_d = tx_data_q;
    cnt_d     = cnt_q;
    ack_d     = '0;
    done_d    = '0;
    err_d     = 1'b0;
    send_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req && !tx_busy) begin
          state_d   = ST_LAUNCH;
          owner_d   = winner;
          tx_data_d = win_data;
          ack_d     = win_hot;
          send_d    = 1'b1;
        end
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT_BUSY;
        cnt_d   = '0;
      end
      ST_WAIT_BUSY, ST_WAIT_DONE: begin
        cnt_d = cnt_q + 16'd1;
        // a done pulse on the terminal-count cycle still completes normally
        if (tx_done) begin
          state_d = ST_GAP;
          done_d  = owner_hot;
        end else if (cnt_q == CNT_TERM) begin
          state_d = ST_GAP;
          err_d   = 1'b1;
        end else if (state_q == ST_WAIT_BUSY && tx_busy) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_GAP: begin
        if (!tx_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      owner_q   <= 3'(N_REQ - 1);
      tx_data_q <= 8'h00;
      cnt_q     <= '0;
      ack_q     <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      send_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      tx_data_q <= tx_data_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      err_q     <= err_d;
      send_q    <= send_d;
    end
  end

  assign ack         = ack_q;
  assign done        = done_q;
  assign err         = err_q;
  assign busy        = (state_q != ST_IDLE);
  assign owner       = owner_q;
  assign tx_send_en  = send_q;
  assign tx_data     = tx_data_q;
  assign tx_baud_set = BAUD_SEL;

endmodule
